// File: rtl/xram_pkg.sv
// rtl/xram_pkg.sv - shared types and constants for the xdata RAM arbiter
//
// Purpose : read-owner encoding, read-port FSM states and the starvation
//           counter width helper shared by the arbiter and its counter.
// Ports   : none (package).

package xram_pkg;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    typedef enum logic [0:0] {
        R_NORM  = 1'b0,
        R_FORCE = 1'b1
    } rd_state_t;

    localparam int STARVE_MAX_DEF = 4;

    // Counter must be able to hold STARVE_MAX itself, hence max+1.
    function automatic int starve_w(input int max);
        return $clog2(max + 1);
    endfunction

    localparam int STARVE_W = starve_w(STARVE_MAX_DEF);

endpackage

// File: rtl/xram_if.sv
// rtl/xram_if.sv - core, DMA and RAM-macro signal bundle for the xdata arbiter
//
// Purpose : groups the core ram_* port, the DMA master port and the RAM
//           macro port into one interface.
// Modports: slave  - the arbiter's view (core/DMA requests in, RAM strobes out)
//           master - the surrounding system's view (core, DMA and RAM macro)

interface xram_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // core side
    logic              c_rd_en;
    logic [ADDR_W-1:0] c_rd_addr;
    logic [DATA_W-1:0] c_rd_data;
    logic              c_rd_vld;
    logic              c_wr_en;
    logic [ADDR_W-1:0] c_wr_addr;
    logic [DATA_W-1:0] c_wr_data;
    // DMA side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvld;
    // RAM macro side
    logic              m_rd_en;
    logic [ADDR_W-1:0] m_rd_addr;
    logic [DATA_W-1:0] m_rd_data;
    logic              m_wr_en;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [DATA_W-1:0] m_wr_data;

    modport slave (
        input  c_rd_en, c_rd_addr, c_wr_en, c_wr_addr, c_wr_data,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rd_data,
        output c_rd_data, c_rd_vld,
        output d_gnt, d_rdata, d_rvld,
        output m_rd_en, m_rd_addr, m_wr_en, m_wr_addr, m_wr_data
    );

    modport master (
        output c_rd_en, c_rd_addr, c_wr_en, c_wr_addr, c_wr_data,
        output d_req, d_we, d_addr, d_wdata,
        output m_rd_data,
        input  c_rd_data, c_rd_vld,
        input  d_gnt, d_rdata, d_rvld,
        input  m_rd_en, m_rd_addr, m_wr_en, m_wr_addr, m_wr_data
    );

endinterface

// File: rtl/xram_starve_ctr.sv
// rtl/xram_starve_ctr.sv - saturating DMA-read starvation counter with clear
//
// Purpose : counts consecutive cycles a DMA read waits, saturating at MAX.
// Ports   : clk, rst (async active-low), inc, clr (clr wins),
//           cnt (registered count), at_max (count being loaded equals MAX).

module xram_starve_ctr
    import xram_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEF,
    parameter int W   = starve_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    // Looks at the value being loaded so the forced slot lands in the cycle
    // right after the MAX-th denial rather than one cycle later.
    assign at_max = (cnt_d == W'(MAX));

endmodule

// File: rtl/xram_arbiter.sv
// rtl/xram_arbiter.sv - core/DMA arbiter for a shared 1-cycle-read xdata RAM
//
// Purpose : core has priority on both RAM ports; DMA gets idle slots plus a
//           forced read slot after STARVE_MAX denied cycles.
// Ports   : clk           - rising-edge clock
//           rst           - asynchronous active-low reset
//           bus (slave)   - core ram_* port, DMA master port, RAM macro port

module xram_arbiter
    import xram_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic  clk,
    input  logic  rst,
    xram_if.slave bus
);

    localparam int SW = starve_w(STARVE_MAX);

    rd_state_t         state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_owner_q, rd_owner_d;

    logic              dma_rd;
    logic              dma_wr;
    logic              rd_gnt;
    logic              wr_gnt;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [SW-1:0]     starve_cnt;
    logic              at_max;

    assign dma_rd = bus.d_req & ~bus.d_we;
    assign dma_wr = bus.d_req &  bus.d_we;

    // Write port: core writes are posted and always pass straight through.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_gnt  = 1'b0;
        if (bus.c_wr_en) begin
            wr_en   = 1'b1;
            wr_addr = bus.c_wr_addr;
            wr_data = bus.c_wr_data;
        end else if (dma_wr) begin
            wr_en   = 1'b1;
            wr_addr = bus.d_addr;
            wr_data = bus.d_wdata;
            wr_gnt  = 1'b1;
        end
    end

    // Read port issue. A deferred core read (pend) goes ahead of everything.
    always_comb begin
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        rd_owner_d  = rd_owner_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        rd_gnt      = 1'b0;
        case (state_q)
            R_NORM: begin
                if (pend_q) begin
                    rd_en      = 1'b1;
                    rd_addr    = pend_addr_q;
                    rd_owner_d = OWN_CORE;
                    pend_d     = 1'b0;
                end else if (bus.c_rd_en) begin
                    rd_en      = 1'b1;
                    rd_addr    = bus.c_rd_addr;
                    rd_owner_d = OWN_CORE;
                end else if (dma_rd) begin
                    rd_en      = 1'b1;
                    rd_addr    = bus.d_addr;
                    rd_owner_d = OWN_DMA;
                    rd_gnt     = 1'b1;
                end
            end
            R_FORCE: begin
                // dma_rd is guaranteed here (request held until granted).
                if (dma_rd) begin
                    rd_en      = 1'b1;
                    rd_addr    = bus.d_addr;
                    rd_owner_d = OWN_DMA;
                    rd_gnt     = 1'b1;
                end
                if (bus.c_rd_en) begin
                    pend_d      = 1'b1;
                    pend_addr_d = bus.c_rd_addr;
                end
            end
            default: begin
                pend_d = 1'b0;
            end
        endcase
        rd_vld_d = rd_en;
    end

    // Kept apart from the issue logic: at_max depends on rd_gnt.
    always_comb begin
        state_d = R_NORM;
        if ((state_q == R_NORM) && at_max) begin
            state_d = R_FORCE;
        end
    end

    xram_starve_ctr #(
        .MAX (STARVE_MAX),
        .W   (SW)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (dma_rd & ~rd_gnt),
        .clr    (~dma_rd | rd_gnt),
        .cnt    (starve_cnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= R_NORM;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_owner_q  <= OWN_CORE;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_owner_q  <= rd_owner_d;
        end
    end

    assign bus.m_rd_en   = rd_en;
    assign bus.m_rd_addr = rd_addr;
    assign bus.m_wr_en   = wr_en;
    assign bus.m_wr_addr = wr_addr;
    assign bus.m_wr_data = wr_data;
    assign bus.d_gnt     = rd_gnt | wr_gnt;
    assign bus.c_rd_vld  = rd_vld_q & (rd_owner_q == OWN_CORE);
    assign bus.d_rvld    = rd_vld_q & (rd_owner_q == OWN_DMA);
    assign bus.c_rd_data = bus.m_rd_data;
    assign bus.d_rdata   = bus.m_rd_data;

    // The core must wait for c_rd_vld; a new read while one is deferred
    // would be lost.
    a_no_rd_while_pend: assert property (@(posedge clk) disable iff (!rst)
        !(pend_q && bus.c_rd_en));
    a_starve_bound: assert property (@(posedge clk) disable iff (!rst)
        starve_cnt <= SW'(STARVE_MAX));

endmodule
